// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1-style datapath: register-site switches,
// reset-style names and default port widths.
package dsp48a1_pkg;

    localparam int REG_ON  = 1;
    localparam int REG_OFF = 0;

    // Reset-style names kept for RSTTYPE compatibility; both map to a synchronous reset.
    localparam logic [63:0] TYPE_SYNC  = "SYNC";
    localparam logic [63:0] TYPE_ASYNC = "ASYNC";

    localparam int A_WIDTH = 18;
    localparam int B_WIDTH = 18;
    localparam int D_WIDTH = 18;
    localparam int C_WIDTH = 48;
    localparam int M_WIDTH = 36;
    localparam int P_WIDTH = 48;

    function automatic bit type_is_legal(input logic [63:0] t);
        return (t == TYPE_SYNC) || (t == TYPE_ASYNC);
    endfunction

endpackage

// File: rtl/reg_mux.sv
// Optional pipeline stage: WIDTH-bit register with clock enable and synchronous
// active-low reset, or a plain wire when the stage is switched off.
module reg_mux
    import dsp48a1_pkg::*;
#(
    parameter int          WIDTH    = 1,
    parameter int          register = REG_ON,
    parameter logic [63:0] TYPE     = TYPE_SYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    if (!type_is_legal(TYPE)) begin : g_bad_type
        $error("reg_mux: TYPE must be \"SYNC\" or \"ASYNC\"");
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("reg_mux: WIDTH must be at least 1");
    end

    if ((register != REG_ON) && (register != REG_OFF)) begin : g_bad_register
        $error("reg_mux: register must be 0 or 1");
    end

    if (register == REG_ON) begin : g_reg
        // Starts at zero so Q is defined before the first edge.
        logic [WIDTH-1:0] r_q = '0;

        // Enable is a feedback mux on the data path; no clock gating.
        always_ff @(posedge clk) begin
            if (!rst)
                r_q <= '0;
            else if (clk_en)
                r_q <= D;
        end

        assign Q = r_q;
    end else begin : g_bypass
        wire w_unused = &{1'b0, clk, rst, clk_en};
        assign Q = D;
    end

endmodule

// File: tb/tb_reg_mux.sv
// Bench for reg_mux: bypass, 18-bit SYNC, 48-bit SYNC and 18-bit ASYNC instances
// against a per-edge reference model of the register rules.
module tb_reg_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [0:0]  d1  = '0;
  logic [17:0] d18 = '0;
  logic [47:0] d48 = '0;
  logic [17:0] d18a = '0;
  logic [0:0]  q1;
  logic [17:0] q18;
  logic [47:0] q48;
  logic [17:0] q18a;

  logic [17:0] exp18  = '0;
  logic [47:0] exp48  = '0;
  logic [17:0] exp18a = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  reg_mux #(.WIDTH(1), .register(0), .TYPE("SYNC")) u_bypass (
    .clk(clk), .rst(rst), .clk_en(en), .D(d1), .Q(q1)
  );
  reg_mux #(.WIDTH(18), .register(1), .TYPE("SYNC")) u_r18 (
    .clk(clk), .rst(rst), .clk_en(en), .D(d18), .Q(q18)
  );
  reg_mux #(.WIDTH(48), .register(1), .TYPE("SYNC")) u_r48 (
    .clk(clk), .rst(rst), .clk_en(en), .D(d48), .Q(q48)
  );
  reg_mux #(.WIDTH(18), .register(1), .TYPE("ASYNC")) u_r18a (
    .clk(clk), .rst(rst), .clk_en(en), .D(d18a), .Q(q18a)
  );

  // ---------------- reference model ----------------
  // What each registered output should hold after every rising edge.
  always @(posedge clk) begin
    exp18  <= (rst == 1'b0) ? 18'd0 : (en ? d18  : exp18);
    exp48  <= (rst == 1'b0) ? 48'd0 : (en ? d48  : exp48);
    exp18a <= (rst == 1'b0) ? 18'd0 : (en ? d18a : exp18a);
  end

  // ---------------- driver helpers ----------------
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if (q18 !== 18'd0 || q48 !== 48'd0 || q18a !== 18'd0) begin
      n_fail++;
      $display("FAIL start_value: q18=%h q48=%h q18a=%h required all 0", q18, q48, q18a);
    end
    d18 = 18'h3ABCD; d48 = 48'hDEAD_BEEF_0001; d18a = 18'h1F0F0;
    rst = 1'b0; en = 1'b1;
    edge_wait();
    n_checks++;
    if (q18 !== 18'd0 || q48 !== 48'd0 || q18a !== 18'd0) begin
      n_fail++;
      $display("FAIL reset: q18=%h q48=%h q18a=%h required all 0", q18, q48, q18a);
    end
  endtask

  task automatic test_bypass();
    // Steps every 5 ns, offset so no step lands on a rising edge.
    for (int i = 0; i < 30; i++) begin
      d1  = 1'($urandom_range(0, 1));
      rst = (i < 15) ? 1'b0 : 1'b1;
      en  = 1'b1;
      #1;
      n_checks++;
      if (q1 !== d1) begin
        n_fail++;
        $display("FAIL bypass step %0d: q=%b required %b (rst=%b)", i, q1, d1, rst);
      end
      #4;
    end
  endtask

  task automatic test_load();
    rst = 1'b1; en = 1'b1;
    d18 = 18'h00000;
    edge_wait();
    d18 = 18'h2A5A5;
    #2;
    n_checks++;
    if (q18 !== 18'h00000) begin
      n_fail++;
      $display("FAIL load_before_edge: q=%h required %h", q18, 18'h00000);
    end
    edge_wait();
    n_checks++;
    if (q18 !== 18'h2A5A5) begin
      n_fail++;
      $display("FAIL load_after_edge: q=%h required %h", q18, 18'h2A5A5);
    end
  endtask

  task automatic test_hold();
    rst = 1'b1; en = 1'b1; d18 = 18'h00123;
    edge_wait();
    en = 1'b0; d18 = 18'h3FFFF;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      n_checks++;
      if (q18 !== 18'h00123) begin
        n_fail++;
        $display("FAIL hold edge %0d: q=%h required %h", i, q18, 18'h00123);
      end
    end
    en = 1'b1;
    edge_wait();
    n_checks++;
    if (q18 !== 18'h3FFFF) begin
      n_fail++;
      $display("FAIL hold_release: q=%h required %h", q18, 18'h3FFFF);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b0; en = 1'b1; d18 = 18'h15555;
    edge_wait();
    n_checks++;
    if (q18 !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_priority: q=%h required %h", q18, 18'd0);
    end
    rst = 1'b1;
    edge_wait();
    // Low pulse confined between edges must leave the register alone.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    n_checks++;
    if (q18 !== 18'h15555) begin
      n_fail++;
      $display("FAIL reset_pulse_between_edges: q=%h required %h", q18, 18'h15555);
    end
    edge_wait();
    n_checks++;
    if (q18 !== 18'h15555) begin
      n_fail++;
      $display("FAIL reset_pulse_next_edge: q=%h required %h", q18, 18'h15555);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1; en = 1'b1; d48 = 48'hFFFF_FFFF_FFFF;
    edge_wait();
    n_checks++;
    if (q48 !== 48'hFFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL midstream_preload: q=%h required %h", q48, 48'hFFFF_FFFF_FFFF);
    end
    rst = 1'b0;
    edge_wait();
    n_checks++;
    if (q48 !== 48'd0) begin
      n_fail++;
      $display("FAIL midstream_clear: q=%h required %h", q48, 48'd0);
    end
    rst = 1'b1; d48 = 48'h1;
    edge_wait();
    n_checks++;
    if (q48 !== 48'h1) begin
      n_fail++;
      $display("FAIL midstream_reload: q=%h required %h", q48, 48'h1);
    end
  endtask

  task automatic test_async_type();
    logic [17:0] v;
    v = 18'($urandom_range(1, 18'h3FFFF));
    rst = 1'b1; en = 1'b1; d18a = v;
    edge_wait();
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (q18a !== v) begin
      n_fail++;
      $display("FAIL async_type_mid_cycle: q=%h required %h", q18a, v);
    end
    edge_wait();
    n_checks++;
    if (q18a !== 18'd0) begin
      n_fail++;
      $display("FAIL async_type_edge: q=%h required %h", q18a, 18'd0);
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      rst  = ($urandom_range(0, 7) != 0);
      en   = ($urandom_range(0, 3) != 0);
      d18  = 18'($urandom);
      d48  = {16'($urandom), 32'($urandom)};
      d18a = 18'($urandom);
      d1   = 1'($urandom_range(0, 1));
      edge_wait();
      n_checks++;
      if (q18 !== exp18 || q48 !== exp48 || q18a !== exp18a || q1 !== d1) begin
        n_fail++;
        $display("FAIL random cycle %0d: q18=%h/%h q48=%h/%h q18a=%h/%h q1=%b/%b (actual/required)",
                 i, q18, exp18, q48, exp48, q18a, exp18a, q1, d1);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    edge_wait();
    test_bypass();
    test_load();
    test_hold();
    test_reset_priority();
    test_reset_midstream();
    test_async_type();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
